// File: rtl/ws2812_pkg.sv
// Shared types, default 50 MHz timing and colour reordering for the WS2812 frame driver.
package ws2812_pkg;

    typedef enum logic [1:0] {IDLE, SEND, LATCH} state_t;

    localparam int DEF_T0H_CYC  = 20;
    localparam int DEF_T1H_CYC  = 40;
    localparam int DEF_TBIT_CYC = 63;
    localparam int DEF_TRES_CYC = 15000;

    // Strip expects green first; decoder delivers 24'hRRGGBB.
    function automatic logic [23:0] grb_order(input logic [23:0] rgb);
        return {rgb[15:8], rgb[23:16], rgb[7:0]};
    endfunction

endpackage

// File: rtl/ws2812_bit_encoder.sv
// Turns one data bit into a single WS2812 bit period; owns the per-bit cycle counter.
module ws2812_bit_encoder
    import ws2812_pkg::*;
#(
    parameter int T0H_CYC  = DEF_T0H_CYC,
    parameter int T1H_CYC  = DEF_T1H_CYC,
    parameter int TBIT_CYC = DEF_TBIT_CYC
) (
    input  logic clock,
    input  logic reset,
    input  logic bit_start,
    input  logic data_bit,
    output logic dout,
    output logic bit_last
);

    localparam int CW = $clog2(TBIT_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(TBIT_CYC - 1);
    localparam logic [CW-1:0] HIGH0    = CW'(T0H_CYC);
    localparam logic [CW-1:0] HIGH1    = CW'(T1H_CYC);

    logic [CW-1:0] bit_cnt;
    logic [CW-1:0] bit_cnt_nxt;
    logic          run;
    logic          bit_val;

    assign bit_cnt_nxt = bit_cnt + CW'(1);
    assign bit_last    = run && (bit_cnt == CNT_LAST);

    // dout is registered for the cycle the counter is about to show, so it never lags the count.
    always_ff @(posedge clock) begin
        if (reset) begin
            bit_cnt <= '0;
            run     <= 1'b0;
            bit_val <= 1'b0;
            dout    <= 1'b0;
        end else if (bit_start) begin
            bit_cnt <= '0;
            run     <= 1'b1;
            bit_val <= data_bit;
            dout    <= 1'b1;
        end else if (bit_last) begin
            bit_cnt <= '0;
            run     <= 1'b0;
            dout    <= 1'b0;
        end else if (run) begin
            bit_cnt <= bit_cnt_nxt;
            dout    <= bit_cnt_nxt < (bit_val ? HIGH1 : HIGH0);
        end
    end

endmodule

// File: rtl/ws2812_frame_driver.sv
// Snapshots a frame of RGB colours and streams it GRB/MSB-first to a WS2812 strip,
// followed by the latch low period and a done pulse.
module ws2812_frame_driver
    import ws2812_pkg::*;
#(
    parameter int N_LEDS   = 11,
    parameter int T0H_CYC  = DEF_T0H_CYC,
    parameter int T1H_CYC  = DEF_T1H_CYC,
    parameter int TBIT_CYC = DEF_TBIT_CYC,
    parameter int TRES_CYC = DEF_TRES_CYC
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [N_LEDS*24-1:0] leds,
    output logic                 dout,
    output logic                 busy,
    output logic                 done
);

    localparam int LW = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
    localparam int RW = (TRES_CYC > 1) ? $clog2(TRES_CYC) : 1;
    localparam logic [LW-1:0] LED_LAST = LW'(N_LEDS - 1);
    localparam logic [RW-1:0] RES_LAST = RW'(TRES_CYC - 1);

    state_t                 state;
    logic [N_LEDS*24-1:0]   frame;
    logic [LW-1:0]          led_idx;
    logic [4:0]             bit_idx;
    logic [RW-1:0]          latch_cnt;

    logic                   enc_last;
    logic                   bit_start;
    logic                   data_bit;
    logic                   last_bit;
    logic                   last_led;
    logic [LW-1:0]          nxt_led;
    logic [4:0]             nxt_bit;
    logic [4:0]             bit_sel;
    logic [23:0]            word;
    logic [23:0]            grb_word;

    // Select the bit that the encoder must start next; in IDLE it is bit 23 of LED 0 taken
    // straight from the input, because the snapshot lands on the same edge.
    always_comb begin
        last_bit = (bit_idx == 5'd23);
        last_led = (led_idx == LED_LAST);
        nxt_led  = last_bit ? led_idx + LW'(1) : led_idx;
        nxt_bit  = last_bit ? 5'd0 : bit_idx + 5'd1;
        word     = '0;
        for (int i = 0; i < N_LEDS; i++) begin
            if (nxt_led == LW'(i)) word = frame[24*i +: 24];
        end
        bit_sel = nxt_bit;
        if (state == IDLE) begin
            word    = leds[23:0];
            bit_sel = 5'd0;
        end
        grb_word  = grb_order(word);
        data_bit  = grb_word[5'd23 - bit_sel];
        bit_start = ((state == IDLE) && start) ||
                    ((state == SEND) && enc_last && !(last_bit && last_led));
    end

    ws2812_bit_encoder #(
        .T0H_CYC  (T0H_CYC),
        .T1H_CYC  (T1H_CYC),
        .TBIT_CYC (TBIT_CYC)
    ) u_bit_encoder (
        .clock     (clock),
        .reset     (reset),
        .bit_start (bit_start),
        .data_bit  (data_bit),
        .dout      (dout),
        .bit_last  (enc_last)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            frame     <= '0;
            led_idx   <= '0;
            bit_idx   <= '0;
            latch_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        frame   <= leds;
                        led_idx <= '0;
                        bit_idx <= '0;
                        busy    <= 1'b1;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    if (enc_last) begin
                        if (last_bit && last_led) begin
                            latch_cnt <= '0;
                            done      <= (TRES_CYC == 1);
                            state     <= LATCH;
                        end else begin
                            led_idx <= nxt_led;
                            bit_idx <= nxt_bit;
                        end
                    end
                end
                LATCH: begin
                    // done is pre-computed one cycle early so it is high during the last latch cycle.
                    if (latch_cnt == RES_LAST) begin
                        latch_cnt <= '0;
                        busy      <= 1'b0;
                        done      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        latch_cnt <= latch_cnt + RW'(1);
                        done      <= (latch_cnt == RES_LAST - RW'(1));
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_frame_driver.sv
// Self-checking bench: records dout/busy/done per cycle and compares against a waveform model.
module tb_ws2812_frame_driver;

    localparam int N_LEDS   = 4;
    localparam int T0H      = 20;
    localparam int T1H      = 40;
    localparam int TBIT     = 63;
    localparam int TRES     = 500;
    localparam int FW       = N_LEDS * 24;
    localparam int NBITS    = N_LEDS * 24;
    localparam int SEND_CYC = NBITS * TBIT;
    localparam int TOTAL    = SEND_CYC + TRES;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [FW-1:0] leds  = '0;
    logic          dout;
    logic          busy;
    logic          done;

    int   n_checks = 0;
    int   n_pass   = 0;
    logic dv [2*TOTAL+4];
    logic bv [2*TOTAL+4];
    logic nv [2*TOTAL+4];

    always #5 clock = ~clock;

    ws2812_frame_driver #(
        .N_LEDS   (N_LEDS),
        .T0H_CYC  (T0H),
        .T1H_CYC  (T1H),
        .TBIT_CYC (TBIT),
        .TRES_CYC (TRES)
    ) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .leds  (leds),
        .dout  (dout),
        .busy  (busy),
        .done  (done)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    function automatic logic [FW-1:0] rand_frame();
        logic [FW-1:0] f;
        for (int i = 0; i < FW; i += 8) f[i +: 8] = 8'($urandom);
        return f;
    endfunction

    // Bit k (0 = first on the wire) of LED led: green MSB..LSB, then red, then blue.
    function automatic bit model_bit(input logic [FW-1:0] f, input int j);
        int unsigned cv;
        int          k;
        cv = 32'(f[(j / 24) * 24 +: 24]);
        k  = j % 24;
        if (k < 8)       return bit'((cv >> (15 - k)) & 1);
        else if (k < 16) return bit'((cv >> (31 - k)) & 1);
        else             return bit'((cv >> (23 - k)) & 1);
    endfunction

    function automatic bit model_dout(input logic [FW-1:0] f, input int s);
        int ph;
        if (s < 1 || s > SEND_CYC) return 1'b0;
        ph = (s - 1) % TBIT;
        return ph < (model_bit(f, (s - 1) / TBIT) ? T1H : T0H);
    endfunction

    function automatic int high_time(input int off, input int j);
        int n = 0;
        for (int c = 1; c <= TBIT; c++) if (dv[off + j*TBIT + c] === 1'b1) n++;
        return n;
    endfunction

    task automatic launch(input logic [FW-1:0] f);
        leds  = f;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Samples n cycles starting at the current negedge; optionally scrambles inputs while sending
    // and raises start exactly in the done cycle.
    task automatic capture(input int n, input bit disturb);
        for (int s = 1; s <= n; s++) begin
            dv[s] = dout;
            bv[s] = busy;
            nv[s] = done;
            if (disturb && s < SEND_CYC) begin
                leds  = rand_frame();
                start = 1'($urandom_range(0, 1));
            end else if (disturb) begin
                start = (s == TOTAL);
            end
            @(negedge clock);
        end
    endtask

    task automatic check_frame(input logic [FW-1:0] f, input int off, input string tag);
        int wave_err = 0, busy_err = 0, done_err = 0, done_at = -1;
        int rises = 0, bad_per = 0, prev = -1;
        logic [23:0] grb, rgb;
        for (int s = 1; s <= TOTAL; s++) begin
            if (dv[off+s] !== model_dout(f, s)) wave_err++;
            if (bv[off+s] !== 1'b1) busy_err++;
            if (nv[off+s] !== (s == TOTAL)) done_err++;
            if (nv[off+s] === 1'b1 && done_at < 0) done_at = s;
            if (s <= SEND_CYC && dv[off+s] === 1'b1 && (s == 1 || dv[off+s-1] === 1'b0)) begin
                rises++;
                if (prev >= 0 && s - prev != TBIT) bad_per++;
                prev = s;
            end
        end
        check({tag, "_wave_err"}, 64'(wave_err), 0);
        check({tag, "_busy_err"}, 64'(busy_err), 0);
        check({tag, "_done_err"}, 64'(done_err), 0);
        check({tag, "_done_at"}, 64'(done_at), 64'(TOTAL));
        check({tag, "_rises"}, 64'(rises), 64'(NBITS));
        check({tag, "_bad_period"}, 64'(bad_per), 0);
        for (int i = 0; i < N_LEDS; i++) begin
            grb = '0;
            for (int k = 0; k < 24; k++)
                grb = {grb[22:0], high_time(off, i*24 + k) > (T0H + T1H) / 2};
            rgb = {grb[15:8], grb[23:16], grb[7:0]};
            check($sformatf("%s_led%0d", tag, i), 64'(rgb), 64'(f[i*24 +: 24]));
        end
    endtask

    initial begin
        logic [FW-1:0] f;
        int            err;

        repeat (3) @(negedge clock);
        check("rst_dout", 64'(dout), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_done", 64'(done), 0);
        reset = 1'b0;
        err = 0;
        repeat (100) begin
            @(negedge clock);
            if (dout !== 1'b0 || busy !== 1'b0 || done !== 1'b0) err++;
        end
        check("idle_outputs", 64'(err), 0);

        // Red-only LED 0: green bits short, red bits long.
        f = '0;
        f[23:0] = 24'hFF0000;
        launch(f);
        capture(TOTAL + 2, 1'b0);
        check_frame(f, 0, "red");
        check("red_b0_high", 64'(high_time(0, 0)), 64'(T0H));
        check("red_b8_high", 64'(high_time(0, 8)), 64'(T1H));
        check("red_busy_after", 64'(bv[TOTAL+1]), 0);

        // Green on first LED, blue on last LED.
        f = '0;
        f[23:0] = 24'h00FF00;
        f[FW-1 -: 24] = 24'h0000FF;
        launch(f);
        capture(TOTAL + 2, 1'b0);
        check_frame(f, 0, "gb");
        check("gb_first_high", 64'(high_time(0, 0)), 64'(T1H));
        check("gb_last_high", 64'(high_time(0, NBITS - 1)), 64'(T1H));

        f = rand_frame();
        launch(f);
        capture(TOTAL + 2, 1'b0);
        check_frame(f, 0, "rand");

        // Inputs scrambled during the frame, start coincident with done.
        f = rand_frame();
        launch(f);
        capture(TOTAL + 2, 1'b1);
        check_frame(f, 0, "dist");
        check("dist_no_restart", 64'(bv[TOTAL+1]), 0);
        check("dist_idle2", 64'(bv[TOTAL+2]), 0);

        // Reset partway through a frame.
        launch(rand_frame());
        capture(3000, 1'b0);
        err = 0;
        for (int s = 1; s <= 3000; s++) if (nv[s] !== 1'b0) err++;
        reset = 1'b1;
        @(negedge clock);
        check("mid_rst_dout", 64'(dout), 0);
        check("mid_rst_busy", 64'(busy), 0);
        check("mid_rst_done", 64'(done), 0);
        check("mid_rst_no_done", 64'(err), 0);
        reset = 1'b0;
        @(negedge clock);
        check("mid_rst_stays_idle", 64'(busy), 0);
        f = rand_frame();
        launch(f);
        capture(TOTAL + 2, 1'b0);
        check_frame(f, 0, "after_rst");

        // start held high: back-to-back frames with one idle cycle between.
        f = rand_frame();
        leds  = f;
        start = 1'b1;
        @(negedge clock);
        capture(2*TOTAL + 1, 1'b0);
        start = 1'b0;
        check_frame(f, 0, "b2b1");
        check("b2b_gap_busy", 64'(bv[TOTAL+1]), 0);
        check("b2b_gap_dout", 64'(dv[TOTAL+1]), 0);
        check_frame(f, TOTAL + 1, "b2b2");
        check("b2b_end_busy", 64'(busy), 0);
        @(negedge clock);
        check("b2b_no_third", 64'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ws2812_frame_driver.md
# ws2812_frame_driver

Serializes one frame of N_LEDS 24-bit colours onto a WS2812 single-wire LED strip. It sits directly downstream of the LED colour decoder and consumes that stage's per-LED colour outputs, concatenated into one flat bus. Each frame is snapshotted on a start pulse and shifted out in GRB order, MSB first, LED 0 first. The frame ends with a latch (reset) low period, after which `done` pulses.

## Interface
- N_LEDS, 11, number of LEDs on the strip
- T0H_CYC, 20, high time of a '0' bit in clock cycles (0.4 µs @ 50 MHz)
- T1H_CYC, 40, high time of a '1' bit in clock cycles (0.8 µs @ 50 MHz)
- TBIT_CYC, 63, total bit period in clock cycles (1.26 µs @ 50 MHz)
- TRES_CYC, 15000, latch low time after the last bit (300 µs @ 50 MHz)

Ports:
- clock  in  1  single system clock; all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to send a frame; sampled only in IDLE
- leds  in  N_LEDS*24  frame colours; LED i at bits [24i+23:24i], format 24'hRRGGBB
- dout  out  1  serial data to the strip; registered output
- busy  out  1  high from the cycle after an accepted start until `done`
- done  out  1  one-cycle pulse when the latch period completes

## Operation
- FSM states: IDLE, SEND, LATCH.
- IDLE:
  - `dout`=0, `busy`=0.
  - On `start`=1, snapshot `leds` into an internal frame register.
  - Clear the bit counter (0..TBIT_CYC-1) and the LED/bit index, then go to SEND.
- SEND:
  - Current LED word is reordered to GRB: {G,R,B} = {c[15:8], c[23:16], c[7:0]}.
  - Bits are sent MSB first, so bit 23 is G[7].
  - `dout`=1 while the bit counter is below T0H_CYC (data bit 0) or T1H_CYC (data bit 1); otherwise `dout`=0.
  - When the bit counter reaches TBIT_CYC-1, advance to the next bit. After bit 0 of LED N_LEDS-1, go to LATCH.
- LATCH:
  - `dout`=0 for exactly TRES_CYC cycles.
  - In the last latch cycle `done`=1, then go to IDLE.
- `start` while `busy`=1 is ignored and is not queued.
- Changes on `leds` after the snapshot do not affect the frame in flight.
- `leds` all zero still sends a full frame of '0' bits. The driver never skips LEDs.
- Arithmetic:
  - Bit counter width is clog2(TBIT_CYC).
  - Latch counter width is clog2(TRES_CYC).
  - LED index width is clog2(N_LEDS).
  - All counters are unsigned and never wrap inside a state.
- Parameter legality: 0 < T0H_CYC < T1H_CYC < TBIT_CYC.

## Timing
- Reset values: `dout`=0, `busy`=0, `done`=0, state IDLE, all counters 0, frame register 0.
- Reset asserted mid-frame: on the next edge the outputs take their reset values, with no `done` pulse. The aborted frame is not resumed.
- `start` is sampled at edge k. At edge k+1: `busy`=1, `dout`=1 (first high of LED 0, bit 23).
- Each bit lasts exactly TBIT_CYC cycles. High time is exactly T0H_CYC or T1H_CYC.
- Total time from accepted `start` to `done`: N_LEDS*24*TBIT_CYC + TRES_CYC cycles.
  - With default parameters this is 11*24*63 + 15000 = 31632 cycles.
- `done` and `busy` fall together. `busy`=0 on the cycle after `done`.
- Earliest next accepted `start` is the cycle `busy`=0. `start` coincident with `done` is ignored.
- `dout` comes from a flop, so there is no combinational path from any input to `dout`.

## Structure
- Shared package `ws2812_pkg`:
  - state enum {IDLE, SEND, LATCH}
  - default timing constants (T0H_CYC, T1H_CYC, TBIT_CYC, TRES_CYC) for 50 MHz
  - GRB reorder function
- One sub-module, `ws2812_bit_encoder`:
  - Takes one data bit plus a `bit_start` strobe.
  - Produces the high/low waveform and a `bit_last` strobe.
  - Owns the bit counter.
- The top holds the FSM, the frame snapshot register, the LED/bit indices and the latch counter.

## Test plan
- Reset, then idle for 100 cycles -> `dout`=0, `busy`=0, `done`=0 throughout.
- LED0 = 24'hFF0000, others 0, then `start` -> bits 0–7 are '0' (20 cycles high) and bits 8–15 are '1' (40 cycles high). Red appears second, after green. `done` fires 31632 cycles after start.
- LED0 = 24'h00FF00 and LED10 = 24'h0000FF -> the first 8 bits are '1'. The last 8 bits of the frame (LED10 blue) are '1'. Every bit period measures 63 cycles.
- Change `leds` and pulse `start` repeatedly during SEND -> the decoded frame equals the original snapshot, and exactly one `done`.
- Assert `reset` at cycle 5000 of a frame -> next cycle `dout`=0, `busy`=0, no `done`. A new `start` sends a complete correct frame.
- `start` held high continuously -> back-to-back frames separated by exactly one idle cycle after each `done`.
